// File: rtl/pool_ctrl_if.sv
// Command, element-stream, pool-datapath and result signals of pool_ctrl.
// The slave modport is the controller's view; master is the surrounding fabric.
interface pool_ctrl_if #(
    parameter int NUM_WIDTH = 16,
    parameter int CNT_WIDTH = 16
);
    logic        [CNT_WIDTH-1:0] cfg_size;
    logic        [CNT_WIDTH-1:0] cfg_count;
    logic                        cfg_valid;
    logic                        cfg_ready;
    logic                        busy;
    logic                        done;
    logic signed [NUM_WIDTH-1:0] in_data;
    logic                        in_valid;
    logic                        in_ready;
    logic                        pool_restart;
    logic signed [NUM_WIDTH-1:0] pool_data;
    logic                        pool_valid;
    logic signed [NUM_WIDTH-1:0] pool_result;
    logic signed [NUM_WIDTH-1:0] out_data;
    logic                        out_valid;
    logic                        out_ready;

    modport slave (
        input  cfg_size, cfg_count, cfg_valid, in_data, in_valid, pool_result, out_ready,
        output cfg_ready, busy, done, in_ready, pool_restart, pool_data, pool_valid,
               out_data, out_valid
    );

    modport master (
        output cfg_size, cfg_count, cfg_valid, in_data, in_valid, pool_result, out_ready,
        input  cfg_ready, busy, done, in_ready, pool_restart, pool_data, pool_valid,
               out_data, out_valid
    );
endinterface

// File: rtl/pool_ctrl.sv
// Sequencer for the pool max-pooling datapath: streams each window into pool,
// waits out the pool pipeline, then returns the window maximum on valid/ready.
//
// state | meaning
// IDLE  | waiting for a command (cfg_ready high)
// FEED  | streaming elements of the current window into pool
// DRAIN | waiting for the last element to reach pool.dn_data
// OUT   | presenting the captured window maximum
// FIN   | one-cycle completion pulse
module pool_ctrl #(
    parameter int NUM_WIDTH = 16,
    parameter int CNT_WIDTH = 16
) (
    input logic        clk,
    input logic        rst_n,
    pool_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FEED  = 3'd1,
        S_DRAIN = 3'd2,
        S_OUT   = 3'd3,
        S_FIN   = 3'd4
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    state_t                      state, state_nxt;
    logic        [CNT_WIDTH-1:0] size_q, size_nxt;
    logic        [CNT_WIDTH-1:0] count_q, count_nxt;
    logic        [CNT_WIDTH-1:0] elem_cnt, elem_nxt;
    logic        [CNT_WIDTH-1:0] win_cnt, win_nxt;
    logic        [1:0]           drain_cnt, drain_nxt;
    logic signed [NUM_WIDTH-1:0] res_q, res_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            size_q    <= '0;
            count_q   <= '0;
            elem_cnt  <= '0;
            win_cnt   <= '0;
            drain_cnt <= '0;
            res_q     <= '0;
        end else begin
            state     <= state_nxt;
            size_q    <= size_nxt;
            count_q   <= count_nxt;
            elem_cnt  <= elem_nxt;
            win_cnt   <= win_nxt;
            drain_cnt <= drain_nxt;
            res_q     <= res_nxt;
        end
    end

    always_comb begin
        state_nxt        = state;
        size_nxt         = size_q;
        count_nxt        = count_q;
        elem_nxt         = elem_cnt;
        win_nxt          = win_cnt;
        drain_nxt        = drain_cnt;
        res_nxt          = res_q;
        bus.cfg_ready    = 1'b0;
        bus.busy         = 1'b1;
        bus.done         = 1'b0;
        bus.in_ready     = 1'b0;
        bus.pool_restart = 1'b0;
        bus.pool_valid   = 1'b0;
        bus.pool_data    = '0;
        bus.out_valid    = 1'b0;
        bus.out_data     = res_q;

        unique case (state)
            S_IDLE: begin
                bus.busy = 1'b0;
                // cfg_ready must read low while rst_n is asserted
                bus.cfg_ready = rst_n;
                if (bus.cfg_valid && rst_n) begin
                    size_nxt  = bus.cfg_size;
                    count_nxt = bus.cfg_count;
                    elem_nxt  = '0;
                    win_nxt   = '0;
                    if (bus.cfg_size == '0 || bus.cfg_count == '0) state_nxt = S_FIN;
                    else                                           state_nxt = S_FEED;
                end
            end
            S_FEED: begin
                bus.in_ready     = 1'b1;
                bus.pool_restart = (elem_cnt == '0);
                bus.pool_valid   = bus.in_valid;
                bus.pool_data    = bus.in_data;
                if (bus.in_valid) begin
                    if (elem_cnt == size_q - CNT_ONE) begin
                        elem_nxt  = '0;
                        drain_nxt = 2'd3;
                        state_nxt = S_DRAIN;
                    end else begin
                        elem_nxt = elem_cnt + CNT_ONE;
                    end
                end
            end
            S_DRAIN: begin
                // four drain cycles line up with the pool pipeline depth
                if (drain_cnt == 2'd0) begin
                    res_nxt   = bus.pool_result;
                    state_nxt = S_OUT;
                end else begin
                    drain_nxt = drain_cnt - 2'd1;
                end
            end
            S_OUT: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    win_nxt = win_cnt + CNT_ONE;
                    if (win_cnt == count_q - CNT_ONE) state_nxt = S_FIN;
                    else                              state_nxt = S_FEED;
                end
            end
            S_FIN: begin
                bus.done  = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_pool_ctrl.sv
// Directed plus randomized bench for pool_ctrl with a behavioural pool stand-in
// and window maxima computed directly from the stimulus list.
module tb_pool_ctrl;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc      = 0;
    int   n_assert = 0;
    int   n_fail   = 0;
    int   stim[$];

    pool_ctrl_if #(.NUM_WIDTH(16), .CNT_WIDTH(16)) bus ();

    pool_ctrl #(.NUM_WIDTH(16), .CNT_WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural pool: running max with restart, result visible 4 cycles after the element.
    logic signed [15:0] acc = '0, p0 = '0, p1 = '0, p2 = '0, p3 = '0;
    always @(posedge clk) begin
        if (bus.pool_valid && (bus.pool_restart || bus.pool_data > acc)) begin
            acc <= bus.pool_data;
            p0  <= bus.pool_data;
        end else begin
            p0 <= acc;
        end
        p1 <= p0;
        p2 <= p1;
        p3 <= p2;
    end
    assign bus.pool_result = p3;

    task automatic chk(input int obs, input int exp, input string tag);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int window_max(input int size, input int w);
        int m;
        m = stim[w * size];
        for (int i = 1; i < size; i++)
            if (stim[w * size + i] > m) m = stim[w * size + i];
        return m;
    endfunction

    function automatic void fill_random(input int k);
        stim.delete();
        for (int i = 0; i < k; i++) stim.push_back(int'($signed(16'($urandom))));
    endfunction

    task automatic check_all_zero(input string tag);
        chk(int'(bus.cfg_ready),    0, {tag, "_cfg_ready"});
        chk(int'(bus.busy),         0, {tag, "_busy"});
        chk(int'(bus.done),         0, {tag, "_done"});
        chk(int'(bus.in_ready),     0, {tag, "_in_ready"});
        chk(int'(bus.pool_restart), 0, {tag, "_pool_restart"});
        chk(int'(bus.pool_valid),   0, {tag, "_pool_valid"});
        chk(int'(bus.out_valid),    0, {tag, "_out_valid"});
        chk(int'(bus.pool_data),    0, {tag, "_pool_data"});
        chk(int'(bus.out_data),     0, {tag, "_out_data"});
    endtask

    task automatic run_cmd(input int size, input int count, input int gap,
                           input int stall_max, input bit poke);
        int exp_q[$];
        int total, n, w, cfg_cyc, last_acc, last_hs, stall_left, held;
        bit fin, seen_out, saw_in, saw_out;
        total = size * count;
        for (int i = 0; i < count && size > 0; i++) exp_q.push_back(window_max(size, i));
        n = 0; w = 0; held = 0;
        last_acc = -100; last_hs = -100; stall_left = stall_max;
        fin = 1'b0; seen_out = 1'b0; saw_in = 1'b0; saw_out = 1'b0;

        @(posedge clk); #1;
        bus.cfg_size  = 16'(size);
        bus.cfg_count = 16'(count);
        bus.cfg_valid = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk(int'(bus.cfg_ready), 1, "cfg_ready_idle");
        cfg_cyc = cyc;

        for (int b = 0; b < 3000 && !fin; b++) begin
            @(posedge clk); #1;
            bus.cfg_valid = poke;
            if (poke) begin
                bus.cfg_size  = 16'($urandom_range(1, 5));
                bus.cfg_count = 16'($urandom_range(1, 5));
            end
            if (n < total) begin
                bus.in_valid = (int'($urandom_range(99)) >= gap);
                bus.in_data  = 16'(stim[n]);
            end else begin
                bus.in_valid = 1'b0;
                bus.in_data  = 16'($urandom);
            end
            bus.out_ready = (stall_left == 0);
            @(negedge clk);

            chk(int'(bus.busy), 1, "busy_high");
            if (poke) chk(int'(bus.cfg_ready), 0, "cfg_ready_busy");
            if (bus.in_ready) saw_in = 1'b1;
            if (cyc == last_hs + 1 && w < count) begin
                chk(int'(bus.in_ready),     1, "refeed_in_ready");
                chk(int'(bus.pool_restart), 1, "refeed_restart");
            end
            if (bus.in_ready && bus.in_valid) begin
                chk(int'(bus.pool_valid),   1, "pool_valid_acc");
                chk(int'(bus.pool_data),    stim[n], "pool_data");
                chk(int'(bus.pool_restart), (n % size == 0) ? 1 : 0, "restart_flag");
                n++;
                if (n % size == 0) last_acc = cyc;
            end else begin
                chk(int'(bus.pool_valid), 0, "pool_valid_idle");
            end
            if (bus.out_valid) begin
                saw_out = 1'b1;
                chk(int'(bus.in_ready), 0, "in_ready_in_out");
                if (!seen_out) begin
                    chk(cyc, last_acc + 5, "out_latency");
                    held     = int'(bus.out_data);
                    seen_out = 1'b1;
                end else begin
                    chk(int'(bus.out_data), held, "out_hold");
                end
                if (bus.out_ready) begin
                    chk(int'(bus.out_data), (w < exp_q.size()) ? exp_q[w] : -99999, "out_data");
                    w++;
                    seen_out   = 1'b0;
                    last_hs    = cyc;
                    stall_left = stall_max;
                end else if (stall_left > 0) begin
                    stall_left--;
                end
            end
            if (bus.done) begin
                fin = 1'b1;
                chk(w, exp_q.size(), "window_count");
                chk(cyc, (total == 0) ? cfg_cyc + 1 : last_hs + 1, "done_timing");
                if (total == 0) begin
                    chk(int'(saw_in),  0, "degen_no_in_ready");
                    chk(int'(saw_out), 0, "degen_no_out_valid");
                end
            end
        end
        if (!fin) chk(0, 1, "timeout_done");

        @(posedge clk); #1;
        bus.cfg_valid = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk(int'(bus.busy),      0, "busy_after_done");
        chk(int'(bus.done),      0, "done_one_cycle");
        chk(int'(bus.cfg_ready), 1, "cfg_ready_after_done");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cfg_size  = '0;
        bus.cfg_count = '0;
        bus.cfg_valid = 1'b0;
        bus.in_data   = 16'h1234;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;

        // reset values while rst_n is held low
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n        = 1'b1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk(int'(bus.cfg_ready), 1, "cfg_ready_post_reset");
        chk(int'(bus.busy),      0, "busy_post_reset");

        // basic window
        stim = '{3, -7, 12, 5};
        run_cmd(4, 1, 0, 0, 1'b0);

        // signed multi-window
        stim = '{-5, -2, -9, 1, 0, 4};
        run_cmd(3, 2, 0, 0, 1'b0);

        // backpressure and input gaps
        stim = '{7, 9, 2, 1};
        run_cmd(2, 2, 40, 10, 1'b0);

        // single-element windows
        stim = '{8, -1, 0};
        run_cmd(1, 3, 0, 0, 1'b0);

        // zero-size and zero-count commands
        stim.delete();
        run_cmd(0, 2, 0, 0, 1'b0);
        run_cmd(3, 0, 0, 0, 1'b0);

        // config poked while busy
        fill_random(6);
        run_cmd(3, 2, 20, 2, 1'b1);

        // randomized commands
        for (int r = 0; r < 8; r++) begin
            int sz, ct;
            sz = int'($urandom_range(1, 6));
            ct = int'($urandom_range(1, 4));
            fill_random(sz * ct);
            run_cmd(sz, ct, int'($urandom_range(0, 50)), int'($urandom_range(0, 3)), r[0]);
        end

        // reset in the middle of DRAIN
        stim = '{50, 60};
        @(posedge clk); #1;
        bus.cfg_size  = 16'd2;
        bus.cfg_count = 16'd1;
        bus.cfg_valid = 1'b1;
        @(negedge clk);
        chk(int'(bus.cfg_ready), 1, "rst_cfg_ready");
        @(posedge clk); #1;
        bus.cfg_valid = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 16'sd50;
        @(negedge clk);
        chk(int'(bus.in_ready), 1, "rst_feed_first");
        @(posedge clk); #1;
        bus.in_data = 16'sd60;
        @(negedge clk);
        chk(int'(bus.in_ready), 1, "rst_feed_last");
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk(int'(bus.in_ready), 0, "rst_in_drain");
        chk(int'(bus.busy),     1, "rst_busy_drain");
        #1 rst_n = 1'b0;
        #1 check_all_zero("rst_async");
        repeat (4) @(posedge clk);
        @(negedge clk);
        check_all_zero("rst_held");
        rst_n = 1'b1;
        stim = '{-3, -4};
        run_cmd(2, 1, 0, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
